// File: rtl/sprite_pkg.sv
// Shared sprite bitmap definitions: command opcodes, writer FSM states and default geometry.
// Imported by the bitmap writer and by the drawers that read the same RAMs.
package sprite_pkg;

  localparam int unsigned SPRITE_WIDTH_X  = 16;
  localparam int unsigned SPRITE_HEIGHT_Y = 16;
  localparam int unsigned SPRITE_ADDR_W   = $clog2(SPRITE_WIDTH_X * SPRITE_HEIGHT_Y);

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_FILL  = 2'd1,
    OP_ERASE = 2'd2,
    OP_RSVD  = 2'd3
  } sprite_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFill,
    StErase,
    StErr
  } sprite_state_e;

endpackage

// File: rtl/xy_scan_counter.sv
// Row-major x/y scan over an inclusive rectangle latched at start.
// last_next flags that the next step lands on the final element.
module xy_scan_counter #(
  parameter int unsigned XW = $clog2(sprite_pkg::SPRITE_WIDTH_X),
  parameter int unsigned YW = $clog2(sprite_pkg::SPRITE_HEIGHT_Y)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          start,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last,
  output logic          last_next
);

  logic [XW-1:0] x_q, x0_q, x1_q, x_nx;
  logic [YW-1:0] y_q, y1_q, y_nx;

  always_comb begin
    x_nx = x_q + XW'(1);
    y_nx = y_q;
    if (x_q == x1_q) begin
      x_nx = x0_q;
      y_nx = y_q + YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else if (start) begin
      x_q  <= x0;
      y_q  <= y0;
      x0_q <= x0;
      x1_q <= x1;
      y1_q <= y1;
    end else if (step) begin
      x_q <= x_nx;
      y_q <= y_nx;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign last      = (x_q == x1_q) && (y_q == y1_q);
  assign last_next = (x_nx == x1_q) && (y_nx == y1_q);

endmodule

// File: rtl/sprite_bitmap_writer.sv
// Write-side engine for sprite bitmap RAMs: LOAD from a pixel stream, FILL with one colour,
// or ERASE a rectangle to transparent. All outputs come straight from flops.
module sprite_bitmap_writer #(
  parameter int unsigned WIDTH_X              = sprite_pkg::SPRITE_WIDTH_X,
  parameter int unsigned HEIGHT_Y             = sprite_pkg::SPRITE_HEIGHT_Y,
  parameter logic [7:0]  TRANSPARENT_ENCODING = sprite_pkg::TRANSPARENT_ENCODING,
  localparam int unsigned XW = $clog2(WIDTH_X),
  localparam int unsigned YW = $clog2(HEIGHT_Y),
  localparam int unsigned AW = $clog2(WIDTH_X * HEIGHT_Y)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [7:0]    cmd_color,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y1,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [7:0]    px_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  import sprite_pkg::*;

  sprite_state_e state_q, state_d;
  sprite_op_e    op;

  logic cmd_ready_q, cmd_ready_d, px_ready_q, px_ready_d, busy_q, busy_d;
  logic wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
  logic [7:0] wr_data_q, wr_data_d, color_q, color_d;

  logic          cnt_start, cnt_step, cnt_last, cnt_last_next;
  logic [XW-1:0] cnt_x0, cnt_x1, cnt_x;
  logic [YW-1:0] cnt_y0, cnt_y1, cnt_y;

  logic cmd_hs, px_hs, rect_bad, pix_last;

  assign op       = sprite_op_e'(cmd_op);
  assign cmd_hs   = cmd_valid && cmd_ready_q;
  assign px_hs    = px_valid && px_ready_q;
  assign rect_bad = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1);
  // While the previous pixel is being written the counter still points at it.
  assign pix_last = wr_en_q ? cnt_last_next : cnt_last;

  xy_scan_counter #(
    .XW (XW),
    .YW (YW)
  ) u_scan (
    .clk       (clk),
    .resetN    (resetN),
    .start     (cnt_start),
    .step      (cnt_step),
    .x0        (cnt_x0),
    .y0        (cnt_y0),
    .x1        (cnt_x1),
    .y1        (cnt_y1),
    .x         (cnt_x),
    .y         (cnt_y),
    .last      (cnt_last),
    .last_next (cnt_last_next)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      px_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      px_ready_q  <= px_ready_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      color_q     <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          case (op)
            OP_LOAD:  state_d = StLoad;
            OP_FILL:  state_d = StFill;
            OP_ERASE: state_d = rect_bad ? StErr : StErase;
            default:  state_d = StErr;
          endcase
        end
      end
      StLoad:          if (done_q) state_d = StIdle;
      StFill, StErase: if (cnt_last) state_d = StIdle;
      StErr:           state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    px_ready_d  = 1'b0;
    wr_en_d     = 1'b0;
    wr_data_d   = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    color_d     = color_q;
    // Re-arming at zero keeps wr_addr at 0 whenever the FSM sits in IDLE.
    cnt_start   = (state_d == StIdle);
    cnt_step    = 1'b0;
    cnt_x0      = '0;
    cnt_y0      = '0;
    cnt_x1      = '0;
    cnt_y1      = '0;
    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          color_d = cmd_color;
          cnt_x1  = XW'(WIDTH_X - 1);
          cnt_y1  = YW'(HEIGHT_Y - 1);
          case (state_d)
            StLoad: begin
              cnt_start  = 1'b1;
              px_ready_d = 1'b1;
            end
            StFill: begin
              cnt_start = 1'b1;
              wr_en_d   = 1'b1;
              wr_data_d = cmd_color;
            end
            StErase: begin
              cnt_start = 1'b1;
              cnt_x0    = cmd_x0;
              cnt_y0    = cmd_y0;
              cnt_x1    = cmd_x1;
              cnt_y1    = cmd_y1;
              wr_en_d   = 1'b1;
              wr_data_d = TRANSPARENT_ENCODING;
              done_d    = (cmd_x0 == cmd_x1) && (cmd_y0 == cmd_y1);
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StLoad: begin
        px_ready_d = px_ready_q && !(px_hs && pix_last);
        wr_en_d    = px_hs;
        wr_data_d  = px_hs ? px_data : 8'h00;
        done_d     = px_hs && pix_last;
        cnt_step   = wr_en_q && !cnt_last;
      end
      StFill, StErase: begin
        if (!cnt_last) begin
          cnt_step  = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = (state_q == StFill) ? color_q : TRANSPARENT_ENCODING;
          done_d    = cnt_last_next;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign px_ready  = px_ready_q;
  assign busy      = busy_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wr_addr   = AW'({cnt_y, cnt_x});

endmodule

// File: tb/tb_sprite_bitmap_writer.sv
// Directed self-checking bench for sprite_bitmap_writer: FILL, ERASE, rejected commands,
// LOAD with stalls, and reset in the middle of a FILL.
module tb_sprite_bitmap_writer;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_color;
  logic [3:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic       px_valid, px_ready;
  logic [7:0] px_data;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_bitmap_writer dut (
    .clk       (clk),
    .resetN    (resetN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_color (cmd_color),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_data   (px_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int k);
    return 8'((k * 37) ^ 32'h5A);
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] color,
                          input logic [3:0] x0, input logic [3:0] y0,
                          input logic [3:0] x1, input logic [3:0] y1);
    int guard = 0;
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_color = color;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_color = ~color;
    cmd_x0    = ~x0;
    cmd_y0    = ~y0;
    cmd_x1    = ~x1;
    cmd_y1    = ~y1;
  endtask

  initial begin
    logic [7:0] exp_a [6];
    logic       hs_pend, saw_done, done_px_ready;
    int         bad, done_addr, k, w, cyc, g;

    exp_a = '{8'd50, 8'd51, 8'd52, 8'd66, 8'd67, 8'd68};
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_color = 8'h00;
    cmd_x0    = 4'd0;
    cmd_y0    = 4'd0;
    cmd_x1    = 4'd0;
    cmd_y1    = 4'd0;
    // Stream's first pixel is offered from the start; it must wait for a LOAD.
    px_valid  = 1'b1;
    px_data   = pix(0);

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({wr_en, done, err, px_ready}), 32'd0);
    check("rst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    check("idle_px_ready", 32'(px_ready), 32'd0);

    // FILL E0
    send_cmd(2'd1, 8'hE0, 4'd0, 4'd0, 4'd0, 4'd0);
    bad = 0;
    done_addr = -1;
    for (int i = 0; i < 256; i++) begin
      if (!(wr_en && wr_addr == 8'(i) && wr_data == 8'hE0 && done == (i == 255) &&
            !cmd_ready && busy && !px_ready)) bad++;
      if (done) done_addr = int'(wr_addr);
      @(negedge clk);
    end
    check("fill_stream_bad", 32'(bad), 32'd0);
    check("fill_done_addr", 32'(done_addr), 32'd255);
    check("fill_after", 32'({cmd_ready, wr_en, busy, done}), 32'b1000);
    check("fill_idle_addr", 32'(wr_addr), 32'd0);

    // ERASE (2,3)-(4,4)
    send_cmd(2'd2, 8'h00, 4'd2, 4'd3, 4'd4, 4'd4);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("erase_addr%0d", i), 32'({wr_en, wr_addr}), 32'({1'b1, exp_a[i]}));
      if (wr_data != 8'hFF || done != (i == 5)) bad++;
      @(negedge clk);
    end
    check("erase_data_done_bad", 32'(bad), 32'd0);
    check("erase_after", 32'({wr_en, cmd_ready}), 32'b01);

    // ERASE single pixel (7,7)
    send_cmd(2'd2, 8'h00, 4'd7, 4'd7, 4'd7, 4'd7);
    check("pt_write", 32'({wr_en, done, wr_addr, wr_data}), 32'({2'b11, 8'd119, 8'hFF}));
    @(negedge clk);
    check("pt_after", 32'({wr_en, done, cmd_ready}), 32'b001);

    // Rejected commands: x0>x1, y0>y1, reserved op
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      send_cmd(2'd2, 8'h00, 4'd5, 4'd0, 4'd4, 4'd0);
      else if (c == 1) send_cmd(2'd2, 8'h00, 4'd0, 4'd5, 4'd0, 4'd4);
      else             send_cmd(2'd3, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0);
      check($sformatf("err%0d_t1", c), 32'({err, wr_en, busy, cmd_ready}), 32'b1010);
      @(negedge clk);
      check($sformatf("err%0d_t2", c), 32'({err, wr_en, busy, cmd_ready}), 32'b0001);
    end

    // LOAD with stalls; pixel 0 has been offered since reset
    check("preload_px_ready", 32'(px_ready), 32'd0);
    send_cmd(2'd0, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0);
    k = 0;
    w = 0;
    cyc = 0;
    bad = 0;
    hs_pend = 1'b0;
    saw_done = 1'b0;
    done_px_ready = 1'b1;
    while (!saw_done && cyc < 1000) begin
      if (wr_en !== hs_pend) bad++;
      if (wr_en) begin
        if (wr_addr !== 8'(w) || wr_data !== pix(w) || done !== (w == 255)) bad++;
        if (done) begin
          saw_done = 1'b1;
          done_px_ready = px_ready;
        end
        w++;
      end else if (done) begin
        bad++;
      end
      px_valid = (k < 256) && !((cyc % 4) == 1 || (cyc % 7) == 3);
      px_data  = pix(k);
      hs_pend  = px_valid && px_ready;
      if (hs_pend) k++;
      cyc++;
      @(negedge clk);
    end
    px_valid = 1'b0;
    check("load_bad", 32'(bad), 32'd0);
    check("load_done_seen", 32'(saw_done), 32'd1);
    check("load_writes", 32'(w), 32'd256);
    check("load_px_ready_at_done", 32'(done_px_ready), 32'd0);
    check("load_after", 32'({cmd_ready, wr_en, busy, px_ready}), 32'b1000);

    // Reset while FILL is at write 100
    px_valid = 1'b1;
    send_cmd(2'd1, 8'h33, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (100) @(negedge clk);
    check("rst_mid_pre", 32'({wr_en, wr_addr}), 32'({1'b1, 8'd100}));
    resetN = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    resetN = 1'b1;
    send_cmd(2'd1, 8'h11, 4'd0, 4'd0, 4'd0, 4'd0);
    check("refill_first", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 8'd0, 8'h11}));
    check("refill_px_ready", 32'(px_ready), 32'd0);
    g = 0;
    while (!done && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("refill_done", 32'({done, wr_addr}), 32'({1'b1, 8'd255}));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_bitmap_writer.md
# sprite_bitmap_writer

Write-side engine for the 16x16, 8-bit-per-pixel sprite bitmap RAMs that the bitmap drawers read with `offsetX`/`offsetY`. It accepts one command at a time from game logic:

- load a full bitmap from a pixel stream,
- fill the bitmap with one colour, or
- erase a sub-rectangle to transparent (brick damage, lost heart).

It emits a write-port stream (`wr_en`/`wr_addr`/`wr_data`) into the RAM, which the drawer reads on its other port.

## Interface
- `WIDTH_X`, 16, bitmap width in pixels; must be a power of 2.
- `HEIGHT_Y`, 16, bitmap height in pixels.
- `TRANSPARENT_ENCODING`, 8'hFF, colour written by erase; drawers do not display this colour.

Ports:
- `clk` in 1: system clock; single clock domain.
- `resetN` in 1: reset is synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 0 LOAD, 1 FILL, 2 ERASE, 3 reserved.
- `cmd_color` in 8: FILL colour.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1` in 4 each: inclusive ERASE rectangle.
- `px_valid` in 1: LOAD pixel present.
- `px_ready` out 1: pixel accepted on `px_valid && px_ready`.
- `px_data` in 8: LOAD pixel, row-major order.
- `wr_en` out 1: RAM write strobe.
- `wr_addr` out 8: RAM address, computed as y*WIDTH_X + x.
- `wr_data` out 8: RAM write data.
- `busy` out 1: high when the FSM is not in IDLE.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1, all other outputs 0.
  - LOAD: `px_ready`=1.
  - FILL: one write per cycle.
  - ERASE: one write per cycle.
  - ERR: one cycle, `err`=1.
- Accepting a command latches all `cmd_*` fields; later changes on the `cmd_*` inputs are ignored until the FSM returns to IDLE.
- Internal scan counters `x`, `y`:
  - `x` counts from x0 to x1; at x1 it wraps to x0 and `y` increments.
  - The last element is reached when x==x1 && y==y1.
  - LOAD and FILL use the rectangle (0,0)..(WIDTH_X-1, HEIGHT_Y-1).
- LOAD: each pixel handshake produces exactly one write. While `px_valid`=0 the FSM stalls, and no write is issued that cycle.
- FILL: writes `cmd_color` to every address.
- ERASE: writes `TRANSPARENT_ENCODING` to every pixel of the rectangle, (x1-x0+1)*(y1-y0+1) writes in total. A single-pixel rectangle (x0==x1, y0==y1) is legal and gives one write.
- Rejected commands: x0>x1, y0>y1, or `cmd_op`==3 all go to ERR. No writes are issued, then the FSM returns to IDLE.
- `px_ready`=0 outside LOAD. Pixels offered outside LOAD are not consumed.
- No abort input. Only reset terminates a command.

## Timing
- Every output is registered. Reset value is 0 for all outputs except `cmd_ready`, which resets to 1.
- Command accepted at edge T:
  - `busy`=1 and `cmd_ready`=0 from T+1.
  - FILL/ERASE: first `wr_en` at T+1, one write per cycle with no gaps.
- LOAD: a pixel accepted at edge P is written at cycle P+1 (latency 1).
- `done` is asserted in the same cycle as the final `wr_en`.
- `cmd_ready` returns to 1 the cycle after `done`, so FILL accepted at T gives writes T+1..T+256, `done` at T+256, `cmd_ready` at T+257.
- ERR: `err` at T+1, `cmd_ready` at T+2.
- Back-to-back commands: minimum one IDLE cycle between them.
- Reset mid-operation: at the next edge `wr_en`=0 and the FSM is in IDLE. RAM contents already written are left as is; no cleanup is done.
- Addresses:
  - `wr_addr` = {y, x} concatenation, which is valid because WIDTH_X is a power of 2.
  - Width is $clog2(WIDTH_X*HEIGHT_Y).
  - No wrap beyond the last address.

## Structure
- `sprite_pkg` holds:
  - the `cmd_op` enum (OP_LOAD, OP_FILL, OP_ERASE, OP_RSVD),
  - the FSM state enum,
  - `TRANSPARENT_ENCODING`,
  - the default sprite dimensions and address width.
  
  Drawers import the same package.
- Sub-module `xy_scan_counter`:
  - Inputs: start with x0/y0/x1/y1, and step.
  - Outputs: x, y, last.
  - Reused by LOAD, FILL and ERASE.

## Test plan
- FILL with `cmd_color`=8'hE0 -> 256 consecutive writes, addr 0..255, data E0; `done` coincides with addr 255; `cmd_ready` back high one cycle later.
- LOAD with random gaps on `px_valid` -> write k carries pixel k at addr k; no write in stall cycles; `done` on the 256th write.
- ERASE (x0,y0,x1,y1)=(2,3,4,4) -> 6 writes of 8'hFF in order addr 50,51,52,66,67,68. Then ERASE (7,7,7,7) -> a single write to addr 119 with `done` on it.
- ERASE (5,0,4,0) and `cmd_op`=3 -> `err` pulse at T+1, no `wr_en`, `cmd_ready` at T+2.
- `resetN` low during FILL at write 100 -> `wr_en`=0 and `busy`=0 on the next edge; a new FILL after release starts at addr 0.
- `px_valid` held high while in IDLE/FILL -> `px_ready`=0 and no pixel is consumed. A subsequent LOAD consumes the stream from its first pixel.
